// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/sequencing controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 6;

  // Control-field values loaded into ID/EX when a bubble is inserted
  localparam logic [1:0] BUBBLE_WB = 2'b00;
  localparam logic [1:0] BUBBLE_M  = 2'b00;
  localparam logic [3:0] BUBBLE_EX = 4'b0000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle between the datapath and the hazard controller.
interface hazard_ctrl_if;
  logic [4:0] Id_rs;
  logic [4:0] Id_rt;
  logic       Id_uses_rt;
  logic       Id_md_valid;
  logic       Id_md_div;
  logic       Ex_MemRead;
  logic [4:0] Ex_rt;
  logic       Ex_branch_taken;
  logic       Pc_write;
  logic       If_Id_write;
  logic       If_Id_flush;
  logic       Id_Ex_bubble;
  logic       Md_start;
  logic       Md_busy;

  modport master (
    output Id_rs, Id_rt, Id_uses_rt, Id_md_valid, Id_md_div,
           Ex_MemRead, Ex_rt, Ex_branch_taken,
    input  Pc_write, If_Id_write, If_Id_flush, Id_Ex_bubble, Md_start, Md_busy
  );

  modport slave (
    input  Id_rs, Id_rt, Id_uses_rt, Id_md_valid, Id_md_div,
           Ex_MemRead, Ex_rt, Ex_branch_taken,
    output Pc_write, If_Id_write, If_Id_flush, Id_Ex_bubble, Md_start, Md_busy
  );
endinterface

// File: rtl/hazard_ctrl_md_counter.sv
// Down-counter for the mul/div stall sequence: load, decrement, zero flag.
module md_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes and mul/div EX stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1 ||
      MUL_CYCLES > (2**CNT_W) - 1 || DIV_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
    $error("hazard_ctrl: MUL_CYCLES/DIV_CYCLES must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  hz_state_t r_state, w_state_nxt;
  logic      r_md_start;
  logic      w_lu;
  logic      w_load, w_dec, w_zero, w_start_nxt;
  logic      w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble;

  assign w_lu = bus.Ex_MemRead && (bus.Ex_rt != 5'd0) &&
                ((bus.Ex_rt == bus.Id_rs) || (bus.Id_uses_rt && (bus.Ex_rt == bus.Id_rt)));

  md_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_load_val(bus.Id_md_div ? DIV_LD : MUL_LD),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_md_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_start <= w_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    w_start_nxt   = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.Ex_branch_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (w_lu) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end else if (bus.Id_md_valid) begin
          // op moves into EX this edge; Md_start then coincides with its first EX cycle
          w_load      = 1'b1;
          w_start_nxt = 1'b1;
          w_state_nxt = MD_WAIT;
        end
      end
      MD_WAIT: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        if (w_zero) w_state_nxt = RUN;
        else        w_dec       = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign bus.Pc_write     = w_pc_write;
  assign bus.If_Id_write  = w_ifid_write;
  assign bus.If_Id_flush  = w_ifid_flush;
  assign bus.Id_Ex_bubble = w_idex_bubble;
  assign bus.Md_start     = r_md_start;
  assign bus.Md_busy      = (r_state == MD_WAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: remaining busy cycles and pending start flag
  int   m_busy  = 0;
  logic m_start = 1'b0;

  int starts_seen = 0;
  int busy_seen   = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mdv, input logic mdd, input logic mr,
                        input logic [4:0] ert, input logic br);
    bus.Id_rs = rs; bus.Id_rt = rt; bus.Id_uses_rt = urt;
    bus.Id_md_valid = mdv; bus.Id_md_div = mdd;
    bus.Ex_MemRead = mr; bus.Ex_rt = ert; bus.Ex_branch_taken = br;
  endtask

  function automatic logic model_lu();
    return bus.Ex_MemRead && bus.Ex_rt != 0 &&
           (bus.Ex_rt == bus.Id_rs || (bus.Id_uses_rt && bus.Ex_rt == bus.Id_rt));
  endfunction

  // Called just after a negedge with inputs applied; ends at the next negedge.
  task automatic step();
    logic lu, epc, eifw, efl, ebub;
    lu = model_lu();
    if (m_busy > 0)               {epc, eifw, efl, ebub} = 4'b0001;
    else if (bus.Ex_branch_taken) {epc, eifw, efl, ebub} = 4'b1111;
    else if (lu)                  {epc, eifw, efl, ebub} = 4'b0001;
    else                          {epc, eifw, efl, ebub} = 4'b1100;
    #1;
    chk("Pc_write",     bus.Pc_write,     epc);
    chk("If_Id_write",  bus.If_Id_write,  eifw);
    chk("If_Id_flush",  bus.If_Id_flush,  efl);
    chk("Id_Ex_bubble", bus.Id_Ex_bubble, ebub);
    chk("Md_busy",      bus.Md_busy,      m_busy > 0);
    chk("Md_start",     bus.Md_start,     m_start);
    if (bus.Md_start) starts_seen++;
    if (bus.Md_busy)  busy_seen++;
    @(posedge clk);
    m_start = 1'b0;
    if (m_busy > 0) m_busy--;
    else if (!bus.Ex_branch_taken && !lu && bus.Id_md_valid) begin
      m_busy  = bus.Id_md_div ? DIV_N : MUL_N;
      m_start = 1'b1;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; checks the immediate effect.
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_busy"}, bus.Md_busy,      1'b0);
    chk({tag, "_start"}, bus.Md_start,    1'b0);
    chk({tag, "_pc"},   bus.Pc_write,     1'b1);
    chk({tag, "_ifw"},  bus.If_Id_write,  1'b1);
    chk({tag, "_bub"},  bus.Id_Ex_bubble, 1'b0);
    m_busy = 0; m_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rst_busy",  bus.Md_busy,      1'b0);
    chk("rst_start", bus.Md_start,     1'b0);
    chk("rst_pc",    bus.Pc_write,     1'b1);
    chk("rst_ifw",   bus.If_Id_write,  1'b1);
    chk("rst_flush", bus.If_Id_flush,  1'b0);
    chk("rst_bub",   bus.Id_Ex_bubble, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // load-use on rs, then cleared hazard
    set_in(5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0); step();
    set_in(5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0); step();
    // $zero destination never stalls
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0); step();
    // rt match only counts when rt is read
    set_in(5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0); step();
    set_in(5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0); step();
    // branch beats load-use and md launch
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1); step();

    // load-use then multiply: one stall, then 4-cycle sequence
    starts_seen = 0; busy_seen = 0;
    set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0); step();
    set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); // branch ignored while busy
    for (int i = 0; i < MUL_N + 2; i++) step();
    chk_int("mul_starts", starts_seen, 1);
    chk_int("mul_busy",   busy_seen,   MUL_N);

    // divide then multiply back-to-back
    starts_seen = 0; busy_seen = 0;
    set_in(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); step();
    set_in(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < DIV_N + 1; i++) step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < MUL_N + 2; i++) step();
    chk_int("b2b_starts", starts_seen, 2);
    chk_int("b2b_busy",   busy_seen,   DIV_N + MUL_N);

    // reset during busy cycle 10 of a divide
    starts_seen = 0;
    set_in(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) step();
    mid_reset("div_rst");
    for (int i = 0; i < 4; i++) step();
    chk_int("div_rst_starts", starts_seen, 1);

    // randomized traffic with small register numbers to provoke collisions
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 149) == 0) mid_reset("rnd_rst");
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It decides, every cycle, whether the PC and the IF/ID register advance, whether IF/ID is flushed, and whether a bubble is inserted into ID/EX. The bubble zeroes the WB/M/EX control fields. The controller covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle multiply/divide operations.

## Interface
Parameters:
- MUL_CYCLES, 4, EX-stage stall cycles for mult/multu
- DIV_CYCLES, 32, EX-stage stall cycles for div/divu
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- Id_rs  in  5  rs field of the instruction in ID
- Id_rt  in  5  rt field of the instruction in ID
- Id_uses_rt  in  1  ID instruction reads rt
- Id_md_valid  in  1  ID instruction is mult/multu/div/divu
- Id_md_div  in  1  1 = divide, 0 = multiply (valid with Id_md_valid)
- Ex_MemRead  in  1  EX instruction is a load (ID/EX M field)
- Ex_rt  in  5  rt of the EX instruction (ID/EX rt output)
- Ex_branch_taken  in  1  branch/jump in EX is taken
- Pc_write  out  1  PC may update
- If_Id_write  out  1  IF/ID may load
- If_Id_flush  out  1  IF/ID loads a nop
- Id_Ex_bubble  out  1  ID/EX loads zero control fields
- Md_start  out  1  one-cycle launch pulse to the mul/div unit
- Md_busy  out  1  mul/div sequence in progress

## Operation
- States: RUN, MD_WAIT. State encoding lives in the package.
- Load-use hazard (LU) = Ex_MemRead && Ex_rt != 0 && (Ex_rt == Id_rs || (Id_uses_rt && Ex_rt == Id_rt)).
- Priority in RUN, highest first:
  1. Ex_branch_taken: If_Id_flush=1, Id_Ex_bubble=1, Pc_write=1, If_Id_write=1. LU and Id_md_valid are ignored that cycle.
  2. LU: Pc_write=0, If_Id_write=0, Id_Ex_bubble=1, If_Id_flush=0. No state change; the hazard self-clears next cycle.
  3. Id_md_valid: normal advance (all enables 1, no bubble/flush). The counter loads (Id_md_div ? DIV_CYCLES : MUL_CYCLES) - 1, and the next state is MD_WAIT.
  4. Otherwise: Pc_write=1, If_Id_write=1, If_Id_flush=0, Id_Ex_bubble=0.
- MD_WAIT:
  - Outputs: Pc_write=0, If_Id_write=0, Id_Ex_bubble=1, If_Id_flush=0.
  - Counter: if counter == 0, next state is RUN; else the counter decrements.
  - Ex_branch_taken, LU and Id_md_valid are ignored (EX holds the mul/div op or bubbles).
- Md_busy = (state == MD_WAIT).
- Md_start is a registered pulse, high exactly in the first MD_WAIT cycle, while the op sits in EX.
- Counter arithmetic is unsigned CNT_W-bit. Values above 2^CNT_W - 1 are a parameter error; the block asserts this in simulation.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=RUN, counter=0, Md_start=0, Md_busy=0.
  - Combinational outputs show RUN behaviour: Pc_write=1, If_Id_write=1, If_Id_flush=0, Id_Ex_bubble=0, qualified by inputs.
- Reset mid-MD_WAIT aborts the sequence; no Md_start reissue.
- Pc_write, If_Id_write, If_Id_flush and Id_Ex_bubble are combinational from state and inputs, with zero latency, so they are valid before the same posedge.
- Multiply latency: the op advances ID→EX at edge E0. MD_WAIT then lasts exactly MUL_CYCLES cycles (DIV_CYCLES for divide). The pipeline resumes advancing at the first RUN cycle after that.
- Back-to-back mul/div: the second op is held in ID during MD_WAIT and starts a new sequence on the first RUN cycle.
- A load in EX followed by mul/div in ID with LU true gives a one-cycle stall first, then the MD sequence.

## Structure
- Package hazard_pkg: state enum/localparams (RUN, MD_WAIT), default latency constants, bubble control-field zero constants.
- Optional sub-module md_cycle_counter (load, decrement, zero flag, CNT_W wide). The remainder is a single always block for state/counter/Md_start plus combinational output logic.

## Test plan
- Load-use: Ex_MemRead=1, Ex_rt=5, Id_rs=5 → Pc_write=0, If_Id_write=0, Id_Ex_bubble=1 for exactly 1 cycle. Repeat with Ex_rt=0 → no stall.
- Branch vs LU: Ex_branch_taken=1 with LU true → If_Id_flush=1, Id_Ex_bubble=1, Pc_write=1, no stall.
- Multiply: Id_md_valid=1, Id_md_div=0 → Md_start high 1 cycle; Md_busy high 4 cycles; stall outputs asserted those 4 cycles, then RUN.
- Divide, back-to-back: div then mult in ID → 32 busy cycles, 1 RUN cycle, then 4 busy cycles; two Md_start pulses.
- Reset mid-divide: assert rst at busy cycle 10 → Md_busy=0 and Pc_write=1 immediately, no further Md_start.
- Branch ignored in MD_WAIT: Ex_branch_taken=1 during busy → no flush, counter unaffected.
